// File: rtl/multicycle_seq.sv
// -----------------------------------------------------------------------------
// multicycle_seq
// Multi-cycle instruction sequencer for the 4-bit-opcode datapath. Each
// instruction is stepped through FETCH / DECODE / EXEC / (MULW) / (MEM) / WB.
// The block handshakes with the instruction and data memories and drives the
// per-phase datapath strobes.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   run                    enable, sampled only at instruction boundaries
//   opcode                 opcode from IR bypass, captured when imem_ack=1
//   zero                   ALU zero flag, used by BEQ in EXEC
//   imem_ack / imem_req    instruction memory handshake
//   dmem_ack / dmem_req    data memory handshake, dmem_we=1 for SW
//   ir_load, rf_wen,       per-phase datapath strobes
//   pc_en, pc_src
//   aluop, alu_src,        datapath selects, registered from the opcode and
//   reg_dst, mem_to_reg    held stable for the whole instruction
//   busy, halted, illegal  status outputs
//   retire_cnt             retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module multicycle_seq #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic [3:0]           opcode,
    input  logic                 zero,
    input  logic                 imem_ack,
    input  logic                 dmem_ack,
    output logic                 imem_req,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 ir_load,
    output logic                 rf_wen,
    output logic                 pc_en,
    output logic                 pc_src,
    output logic [2:0]           aluop,
    output logic                 alu_src,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 busy,
    output logic                 halted,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MULW   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_HALTED = 3'd7
    } state_t;

    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd7;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_HALT = 4'd15;

    // EXEC already counts as the first MUL cycle; MULW runs from this
    // preload down to zero inclusive.
    localparam logic [3:0] MUL_LOAD   = 4'(MUL_CYCLES - 2);
    localparam bit         MUL_SINGLE = (MUL_CYCLES == 32'sd1);

    // Opcodes 11..14 are undefined.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'd11) && (op <= 4'd14);
    endfunction

    // ALU operation for a given opcode; memory ops use ADD, BEQ uses SUB.
    function automatic logic [2:0] dec_aluop(input logic [3:0] op);
        logic [2:0] r;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3,
            4'd4, 4'd5, 4'd6, 4'd7: r = op[2:0];
            OP_LW, OP_SW:           r = 3'b000;
            OP_BEQ:                 r = 3'b001;
            default:                r = 3'b000;
        endcase
        return r;
    endfunction

    state_t                state_r, state_s;
    state_t                boundary_s;
    logic [3:0]            op_r;
    logic [3:0]            mul_cnt_r, mul_cnt_s;
    logic [2:0]            aluop_r;
    logic                  alu_src_r;
    logic                  reg_dst_r;
    logic                  mem_to_reg_r;
    logic [CNT_WIDTH-1:0]  retire_cnt_r;

    assign boundary_s = run ? S_FETCH : S_IDLE;

    // Next-state and per-phase strobe decode from the registered state.
    always_comb begin
        state_s   = state_r;
        mul_cnt_s = mul_cnt_r;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_load   = 1'b0;
        rf_wen    = 1'b0;
        pc_en     = 1'b0;
        pc_src    = 1'b0;
        illegal   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (run) begin
                    state_s = S_FETCH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_s = S_DECODE;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (op_r == OP_HALT) begin
                    state_s = S_HALTED;
                end else if (is_illegal(op_r)) begin
                    // Undefined opcode retires as a NOP.
                    illegal = 1'b1;
                    pc_en   = 1'b1;
                    state_s = boundary_s;
                end else begin
                    state_s = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_r)
                    OP_MUL: begin
                        if (MUL_SINGLE) begin
                            state_s = S_WB;
                        end else begin
                            mul_cnt_s = MUL_LOAD;
                            state_s   = S_MULW;
                        end
                    end
                    OP_LW, OP_SW: begin
                        state_s = S_MEM;
                    end
                    OP_BEQ: begin
                        pc_en   = 1'b1;
                        pc_src  = zero;
                        state_s = boundary_s;
                    end
                    default: begin
                        state_s = S_WB;
                    end
                endcase
            end
            S_MULW: begin
                if (mul_cnt_r == 4'd0) begin
                    state_s = S_WB;
                end else begin
                    mul_cnt_s = mul_cnt_r - 4'd1;
                    state_s   = S_MULW;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_r == OP_SW);
                if (dmem_ack) begin
                    if (op_r == OP_SW) begin
                        pc_en   = 1'b1;
                        state_s = boundary_s;
                    end else begin
                        state_s = S_WB;
                    end
                end else begin
                    state_s = S_MEM;
                end
            end
            S_WB: begin
                rf_wen  = 1'b1;
                pc_en   = 1'b1;
                state_s = boundary_s;
            end
            S_HALTED: begin
                state_s = S_HALTED;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, MUL hold counter and opcode latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            mul_cnt_r <= 4'd0;
            op_r      <= 4'd0;
        end else begin
            state_r   <= state_s;
            mul_cnt_r <= mul_cnt_s;
            if (ir_load) begin
                op_r <= opcode;
            end else begin
                op_r <= op_r;
            end
        end
    end

    // Datapath selects are captured with the opcode so they are already
    // valid in DECODE and cannot glitch during the instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluop_r      <= 3'b000;
            alu_src_r    <= 1'b0;
            reg_dst_r    <= 1'b0;
            mem_to_reg_r <= 1'b0;
        end else if (ir_load) begin
            aluop_r      <= dec_aluop(opcode);
            alu_src_r    <= (opcode == OP_SLL) || (opcode == OP_SRL);
            reg_dst_r    <= (opcode == OP_SW) || (opcode == OP_BEQ);
            mem_to_reg_r <= (opcode == OP_LW);
        end else begin
            aluop_r      <= aluop_r;
            alu_src_r    <= alu_src_r;
            reg_dst_r    <= reg_dst_r;
            mem_to_reg_r <= mem_to_reg_r;
        end
    end

    // Retired-instruction counter; pc_en fires exactly once per retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (pc_en) begin
            retire_cnt_r <= retire_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

    assign aluop      = aluop_r;
    assign alu_src    = alu_src_r;
    assign reg_dst    = reg_dst_r;
    assign mem_to_reg = mem_to_reg_r;
    assign retire_cnt = retire_cnt_r;
    assign busy       = (state_r != S_IDLE) && (state_r != S_HALTED);
    assign halted     = (state_r == S_HALTED);

endmodule

// File: tb/tb_multicycle_seq.sv
// -----------------------------------------------------------------------------
// tb_multicycle_seq
// Directed self-checking bench for multicycle_seq. Two instances share the
// stimulus: dut (MUL_CYCLES=4, 16-bit counter) and dut_b (MUL_CYCLES=1,
// 4-bit counter so the wrap is reachable quickly). sel_b picks which
// instance the instruction monitor observes.
// -----------------------------------------------------------------------------
module tb_multicycle_seq;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [3:0]  opcode;
    logic        zero;
    logic        imem_ack;
    logic        dmem_ack;

    logic        imem_req, dmem_req, dmem_we, ir_load, rf_wen, pc_en, pc_src;
    logic [2:0]  aluop;
    logic        alu_src, reg_dst, mem_to_reg, busy, halted, illegal;
    logic [15:0] retire_cnt;

    logic        imem_req_b, dmem_req_b, dmem_we_b, ir_load_b, rf_wen_b, pc_en_b, pc_src_b;
    logic [2:0]  aluop_b;
    logic        alu_src_b, reg_dst_b, mem_to_reg_b, busy_b, halted_b, illegal_b;
    logic [3:0]  retire_cnt_b;

    logic        sel_b;

    multicycle_seq #(.MUL_CYCLES(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_load(ir_load), .rf_wen(rf_wen), .pc_en(pc_en), .pc_src(pc_src),
        .aluop(aluop), .alu_src(alu_src), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .busy(busy), .halted(halted),
        .illegal(illegal), .retire_cnt(retire_cnt)
    );

    multicycle_seq #(.MUL_CYCLES(1), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req_b), .dmem_req(dmem_req_b), .dmem_we(dmem_we_b),
        .ir_load(ir_load_b), .rf_wen(rf_wen_b), .pc_en(pc_en_b), .pc_src(pc_src_b),
        .aluop(aluop_b), .alu_src(alu_src_b), .reg_dst(reg_dst_b),
        .mem_to_reg(mem_to_reg_b), .busy(busy_b), .halted(halted_b),
        .illegal(illegal_b), .retire_cnt(retire_cnt_b)
    );

    // Monitored view of whichever instance is under test.
    logic       mon_dmem_req, mon_dmem_we, mon_ir_load, mon_rf_wen, mon_pc_en, mon_pc_src;
    logic [2:0] mon_aluop;
    logic       mon_alu_src, mon_reg_dst, mon_mem_to_reg, mon_halted, mon_illegal;

    assign mon_dmem_req   = sel_b ? dmem_req_b   : dmem_req;
    assign mon_dmem_we    = sel_b ? dmem_we_b    : dmem_we;
    assign mon_ir_load    = sel_b ? ir_load_b    : ir_load;
    assign mon_rf_wen     = sel_b ? rf_wen_b     : rf_wen;
    assign mon_pc_en      = sel_b ? pc_en_b      : pc_en;
    assign mon_pc_src     = sel_b ? pc_src_b     : pc_src;
    assign mon_aluop      = sel_b ? aluop_b      : aluop;
    assign mon_alu_src    = sel_b ? alu_src_b    : alu_src;
    assign mon_reg_dst    = sel_b ? reg_dst_b    : reg_dst;
    assign mon_mem_to_reg = sel_b ? mem_to_reg_b : mem_to_reg;
    assign mon_halted     = sel_b ? halted_b     : halted;
    assign mon_illegal    = sel_b ? illegal_b    : illegal;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-instruction measurements filled in by exec_instr.
    int         m_len, m_rf, m_rf_cyc, m_pc, m_ill, m_ir, m_alu_bad;
    int         m_dreq, m_dwe, m_m2r, m_reg_dst, m_alu_src;
    logic       m_pcsrc, m_pc_in_mem;
    logic [2:0] m_aluop;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one instruction starting #1 after the edge that entered FETCH.
    // dmem_ack rises after dly full cycles of dmem_req; run drops from cycle
    // drop_cyc on. Returns #1 after the edge following the retire cycle.
    task automatic exec_instr(input logic [3:0] op, input logic zero_v,
                              input int dly, input int drop_cyc);
        int  dcnt;
        bit  done;
        opcode = op;
        zero   = zero_v;
        m_len = 0; m_rf = 0; m_rf_cyc = 0; m_pc = 0; m_ill = 0; m_ir = 0;
        m_alu_bad = 0; m_dreq = 0; m_dwe = 0; m_m2r = 0; m_reg_dst = 0;
        m_alu_src = 0; m_pcsrc = 1'b0; m_pc_in_mem = 1'b0; m_aluop = 3'b000;
        dcnt = 0;
        done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            run = (c < drop_cyc);
            if (mon_dmem_req) dcnt++;
            dmem_ack = mon_dmem_req && (dcnt > dly);
            @(negedge clk);
            m_len = c;
            if (c == 1) m_ir = int'(mon_ir_load);
            if (c == 2) begin
                m_aluop   = mon_aluop;
                m_m2r     = int'(mon_mem_to_reg);
                m_reg_dst = int'(mon_reg_dst);
                m_alu_src = int'(mon_alu_src);
            end
            if (c > 2 && mon_aluop !== m_aluop) m_alu_bad++;
            if (mon_rf_wen) begin
                m_rf++;
                m_rf_cyc = c;
            end
            if (mon_illegal) m_ill++;
            if (mon_dmem_req) m_dreq++;
            if (mon_dmem_we) m_dwe++;
            if (mon_pc_en) begin
                m_pc++;
                m_pcsrc     = mon_pc_src;
                m_pc_in_mem = mon_dmem_req;
                done        = 1'b1;
            end
            if (mon_halted) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) check_val("instr_timeout", 32'd0, 32'd1);
        dmem_ack = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        run      = 1'b0;
        opcode   = 4'd0;
        zero     = 1'b0;
        imem_ack = 1'b1;
        dmem_ack = 1'b0;
        sel_b    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_val("reset_outputs",
                  {imem_req, dmem_req, dmem_we, ir_load, rf_wen, pc_en, pc_src, aluop,
                   alu_src, reg_dst, mem_to_reg, busy, halted, illegal, retire_cnt}, 32'd0);

        @(negedge clk);
        rst_n  = 1'b1;
        run    = 1'b1;
        @(posedge clk);
        #1;

        // ADD then SUB, zero-wait: 4 cycles each, rf_wen in cycle 4.
        exec_instr(4'd0, 1'b0, 0, 99);
        check_val("add_len", m_len, 32'd4);
        check_val("add_rf_cnt", m_rf, 32'd1);
        check_val("add_rf_cyc", m_rf_cyc, 32'd4);
        check_val("add_ir_load", m_ir, 32'd1);
        check_val("add_aluop", m_aluop, 32'd0);
        exec_instr(4'd1, 1'b0, 0, 99);
        check_val("sub_len", m_len, 32'd4);
        check_val("sub_aluop", m_aluop, 32'd1);
        check_val("sub_retire_cnt", retire_cnt, 32'd2);

        // SLL uses the shamt operand.
        exec_instr(4'd5, 1'b0, 0, 99);
        check_val("sll_aluop", m_aluop, 32'd5);
        check_val("sll_alu_src", m_alu_src, 32'd1);

        // MUL with MUL_CYCLES=4: 3+4 cycles, one rf_wen, aluop stable.
        exec_instr(4'd7, 1'b0, 0, 99);
        check_val("mul4_len", m_len, 32'd7);
        check_val("mul4_rf_cnt", m_rf, 32'd1);
        check_val("mul4_aluop", m_aluop, 32'd7);
        check_val("mul4_aluop_stable", m_alu_bad, 32'd0);

        // LW with dmem_ack three cycles late: 4 cycles of dmem_req.
        exec_instr(4'd8, 1'b0, 3, 99);
        check_val("lw_len", m_len, 32'd8);
        check_val("lw_dmem_req_cyc", m_dreq, 32'd4);
        check_val("lw_dmem_we_cyc", m_dwe, 32'd0);
        check_val("lw_mem_to_reg", m_m2r, 32'd1);
        check_val("lw_rf_cyc", m_rf_cyc, 32'd8);

        // SW zero-wait: write, no rf_wen, pc_en in the ack (MEM) cycle.
        exec_instr(4'd9, 1'b0, 0, 99);
        check_val("sw_len", m_len, 32'd4);
        check_val("sw_dmem_we_cyc", m_dwe, 32'd1);
        check_val("sw_rf_cnt", m_rf, 32'd0);
        check_val("sw_pc_in_mem", m_pc_in_mem, 32'd1);

        // BEQ taken and not taken.
        exec_instr(4'd10, 1'b1, 0, 99);
        check_val("beq_t_len", m_len, 32'd3);
        check_val("beq_t_pc_src", m_pcsrc, 32'd1);
        check_val("beq_t_rf_cnt", m_rf, 32'd0);
        check_val("beq_t_reg_dst", m_reg_dst, 32'd1);
        check_val("beq_t_aluop", m_aluop, 32'd1);
        exec_instr(4'd10, 1'b0, 0, 99);
        check_val("beq_nt_len", m_len, 32'd3);
        check_val("beq_nt_pc_src", m_pcsrc, 32'd0);
        check_val("beq_nt_rf_cnt", m_rf, 32'd0);

        // Illegal opcode 12: 2 cycles, single illegal pulse, retired.
        exec_instr(4'd12, 1'b0, 0, 99);
        check_val("ill_len", m_len, 32'd2);
        check_val("ill_pulse_cnt", m_ill, 32'd1);
        check_val("ill_pc_cnt", m_pc, 32'd1);
        check_val("ill_retire_cnt", retire_cnt, 32'd9);

        // ADD with run dropped in EXEC: completes, then idles.
        exec_instr(4'd0, 1'b0, 0, 3);
        check_val("drop_len", m_len, 32'd4);
        check_val("drop_rf_cnt", m_rf, 32'd1);
        check_val("drop_retire_cnt", retire_cnt, 32'd10);
        check_val("drop_idle", {busy, imem_req, halted}, 32'd0);
        @(posedge clk);
        #1;
        check_val("drop_idle_hold", {busy, imem_req}, 32'd0);

        // Reset asserted in the MEM cycle of LW (ack never arrives).
        opcode = 4'd8;
        run    = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_val("lw_abort_in_mem", {busy, dmem_req}, 32'd3);
        rst_n = 1'b0;
        #1;
        check_val("lw_abort_outputs",
                  {imem_req, dmem_req, dmem_we, ir_load, rf_wen, pc_en, pc_src, aluop,
                   alu_src, reg_dst, mem_to_reg, busy, halted, illegal, retire_cnt}, 32'd0);

        // HALT: absorbing with run held high.
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;
        @(posedge clk);
        #1;
        exec_instr(4'd15, 1'b0, 0, 99);
        check_val("halt_state", {halted, busy}, 32'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("halt_absorb", {halted, busy, imem_req, pc_en}, 32'd8);
        end
        check_val("halt_retire_cnt", retire_cnt, 32'd0);

        // Second instance: MUL_CYCLES=1 and 4-bit counter wrap.
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        sel_b = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;
        @(posedge clk);
        #1;
        exec_instr(4'd7, 1'b0, 0, 99);
        check_val("mul1_len", m_len, 32'd4);
        check_val("mul1_rf_cnt", m_rf, 32'd1);
        check_val("mul1_retire_cnt", retire_cnt_b, 32'd1);
        for (int i = 0; i < 14; i++) begin
            exec_instr(4'd11, 1'b0, 0, 99);
        end
        check_val("cnt_at_max", retire_cnt_b, 32'd15);
        exec_instr(4'd11, 1'b0, 0, 99);
        check_val("cnt_wrap", retire_cnt_b, 32'd0);
        run = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
